deser_phase_ctrl: RTL

//  Sampling-phase controller for the 8x oversampling front end of the deser400 path.
//  - Accumulates the per-phase transition flags (trans) over a fixed window.
//  - Picks the sampling phase opposite the dominant edge phase, then emits one recovered bit per clk.
//  - Reports lock status and phase-wrap slips to the downstream decoder.

---
 rtl/deser_phase_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/deser_phase_ctrl.sv
// deser_phase_ctrl: sampling-phase controller for the 8x oversampling deser400 front end.
// Optional override port pair (force_req, force_phase) is built when DESER_PHASE_FORCE_EN is defined.
module deser_phase_ctrl #(
  parameter int WIN_LOG2  = 6,
  parameter int CNT_W     = 8,
  parameter int MIN_TRANS = 4,
  parameter int LOCK_WIN  = 3
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       enable,
  input  logic [7:0] samples,
  input  logic [7:0] trans,
`ifdef DESER_PHASE_FORCE_EN
  input  logic       force_req,   // "force" is a reserved word, hence the suffix
  input  logic [2:0] force_phase,
`endif
  output logic [2:0] phase,
  output logic       dout,
  output logic       dout_valid,
  output logic       locked,
  output logic       slip
);

  localparam int SUM_W   = CNT_W + 3;
  localparam int AGREE_W = $clog2(LOCK_WIN + 1);

  typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt [8];
  logic [WIN_LOG2-1:0]  timer;
  logic [AGREE_W-1:0]   agree;
  logic [AGREE_W-1:0]   agree_inc;
  logic [2:0]           edge_idx;
  logic [2:0]           cand;
  logic [2:0]           delta;
  logic [CNT_W-1:0]     max_cnt;
  logic [SUM_W-1:0]     sum;
  logic                 win_end;
  logic                 update_ok;
  logic                 near;
  logic                 wrap;
  logic                 force_active;

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    edge_idx = 3'd0;
    max_cnt  = cnt[0];
    sum      = '0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + SUM_W'(cnt[i]);
      // strict '>' keeps the lowest index when counts tie
      if (cnt[i] > max_cnt) begin
        max_cnt  = cnt[i];
        edge_idx = 3'(i);
      end
    end
  end

  assign cand      = edge_idx + 3'd4;
  assign delta     = cand - phase;
  assign near      = (delta == 3'd1) || (delta == 3'd7);
  assign wrap      = ((phase == 3'd7) && (cand == 3'd0)) || ((phase == 3'd0) && (cand == 3'd7));
  assign win_end   = enable && (timer == '1);
  assign update_ok = win_end && (sum >= SUM_W'(MIN_TRANS)) && !force_active;
  assign agree_inc = (agree == AGREE_W'(LOCK_WIN)) ? agree : agree + 1'b1;

`ifdef DESER_PHASE_FORCE_EN
  logic force_q;
  assign force_active = force_req;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) force_q <= 1'b0;
    else        force_q <= force_req;
  end
`else
  assign force_active = 1'b0;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state  <= IDLE;
      timer  <= '0;
      agree  <= '0;
      phase  <= 3'd0;
      locked <= 1'b0;
      slip   <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other state.
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      slip <= 1'b0;
      if (!enable) begin
        // leaving the run state discards the window; phase is held
        state  <= IDLE;
        timer  <= '0;
        agree  <= '0;
        locked <= 1'b0;
        for (int i = 0; i < 8; i++) cnt[i] <= '0;
      end else begin
        timer <= timer + 1'b1;
        for (int i = 0; i < 8; i++) begin
          if (win_end)              cnt[i] <= CNT_W'(trans[i]);
          else if (cnt[i] != '1)    cnt[i] <= cnt[i] + CNT_W'(trans[i]);
        end
        case (state)
          IDLE: state <= ACQ;
          ACQ: begin
            if (update_ok) begin
              phase  <= cand;
              agree  <= AGREE_W'(1);
              locked <= (LOCK_WIN <= 1);
              slip   <= wrap;
              state  <= TRACK;
            end
          end
          TRACK: begin
            if (update_ok) begin
              if (cand == phase) begin
                agree <= agree_inc;
                if (agree_inc == AGREE_W'(LOCK_WIN)) locked <= 1'b1;
              end else if (near) begin
                // one-step drift follows the edge without losing agreement
                phase <= cand;
                slip  <= wrap;
              end else begin
                phase  <= cand;
                agree  <= AGREE_W'(1);
                locked <= (LOCK_WIN <= 1);
                slip   <= wrap;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
`ifdef DESER_PHASE_FORCE_EN
      if (force_req) begin
        phase  <= force_phase;
        locked <= 1'b1;
        slip   <= 1'b0;
      end else if (force_q && enable) begin
        state  <= ACQ;
        agree  <= '0;
        locked <= 1'b0;
      end
`endif
    end
  end

  // slip is high for the cycle after a wrap update, which blanks exactly one valid
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= samples[phase];
      dout_valid <= enable & locked & ~slip;
    end
  end

endmodule
